// File: rtl/instruction_fetch.sv
// Fetch stage: PC, sync imem read, captured word held for decode.
// Ports: clk/reset, mem_* imem side, stall/ack/pc_load, instr_* out.
module instruction_fetch #(
  parameter int WIDTH = 16,
  parameter int ADDR_BITS = 16,
  parameter logic [ADDR_BITS-1:0] RESET_PC = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic                 mem_rd_en,
  input  logic [WIDTH-1:0]     mem_rd_data,
  input  logic                 stall,
  input  logic                 instr_ack,
  input  logic                 pc_load,
  input  logic [ADDR_BITS-1:0] pc_load_addr,
  output logic [WIDTH-1:0]     instr_out,
  output logic                 instr_valid,
  output logic [ADDR_BITS-1:0] instr_pc,
  output logic [ADDR_BITS-1:0] pc_plus1
);

  localparam logic [ADDR_BITS-1:0] ONE = ADDR_BITS'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_VALID
  } state_t;

  state_t state;
  state_t state_nx;

  logic [ADDR_BITS-1:0] fetch_pc;
  logic capture;
  logic release_i;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // A redirect restarts the fetch from any state.
  always_comb begin
    state_nx = state;
    if (pc_load) begin
      state_nx = S_REQ;
    end else begin
      case (state)
        S_IDLE:  state_nx = S_REQ;
        S_REQ:   state_nx = S_WAIT;
        S_WAIT:  state_nx = S_VALID;
        S_VALID: begin
          if (instr_ack && !stall) begin
            state_nx = S_REQ;
          end
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_comb begin
    mem_rd_en = (state == S_REQ);
    mem_addr  = fetch_pc;
    pc_plus1  = instr_pc + ONE;
    capture   = (state == S_WAIT) && !pc_load;
    release_i = (state == S_VALID) && instr_ack
             && !stall && !pc_load;
  end

  // pc_load squashes an in-flight read by
  // skipping the capture on the WAIT edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc    <= RESET_PC;
      instr_out   <= '0;
      instr_valid <= 1'b0;
      instr_pc    <= RESET_PC;
    end else if (pc_load) begin
      fetch_pc    <= pc_load_addr;
      instr_valid <= 1'b0;
    end else if (capture) begin
      instr_out   <= mem_rd_data;
      instr_pc    <= fetch_pc;
      fetch_pc    <= fetch_pc + ONE;
      instr_valid <= 1'b1;
    end else if (release_i) begin
      instr_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: vector table plus
// directed redirect / wrap / reset sequences.
module tb_instruction_fetch;

  logic        clk;
  logic        reset;
  logic [15:0] mem_addr;
  logic        mem_rd_en;
  logic [15:0] mem_rd_data;
  logic        stall;
  logic        instr_ack;
  logic        pc_load;
  logic [15:0] pc_load_addr;
  logic [15:0] instr_out;
  logic        instr_valid;
  logic [15:0] instr_pc;
  logic [15:0] pc_plus1;

  int n_tests;
  int n_fail;

  logic [15:0] mem [0:65535];

  typedef struct {
    logic        stall;
    logic        ack;
    logic        load;
    logic [15:0] load_addr;
    logic        valid;
    logic [15:0] out;
    logic [15:0] pc;
    logic [15:0] plus1;
    logic        rd_en;
    logic [15:0] addr;
  } vec_t;

  vec_t vecs [14];

  instruction_fetch #(
    .WIDTH(16),
    .ADDR_BITS(16),
    .RESET_PC(16'h0000)
  ) dut (
    .clk(clk),
    .reset(reset),
    .mem_addr(mem_addr),
    .mem_rd_en(mem_rd_en),
    .mem_rd_data(mem_rd_data),
    .stall(stall),
    .instr_ack(instr_ack),
    .pc_load(pc_load),
    .pc_load_addr(pc_load_addr),
    .instr_out(instr_out),
    .instr_valid(instr_valid),
    .instr_pc(instr_pc),
    .pc_plus1(pc_plus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= mem[mem_addr];
  end

  task automatic chk(input string name,
                     input logic [15:0] got,
                     input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               name, got, exp);
    end
  endtask

  task automatic chk_all(input string tag,
                         input logic v,
                         input logic [15:0] o,
                         input logic [15:0] p,
                         input logic [15:0] p1,
                         input logic r,
                         input logic [15:0] a);
    chk({tag, " valid"}, {15'd0, instr_valid}, {15'd0, v});
    chk({tag, " out"}, instr_out, o);
    chk({tag, " pc"}, instr_pc, p);
    chk({tag, " plus1"}, pc_plus1, p1);
    chk({tag, " rd_en"}, {15'd0, mem_rd_en}, {15'd0, r});
    chk({tag, " addr"}, mem_addr, a);
  endtask

  task automatic tick(input logic s, input logic a,
                      input logic l,
                      input logic [15:0] la);
    stall = s;
    instr_ack = a;
    pc_load = l;
    pc_load_addr = la;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(
    input logic s, input logic a, input logic l,
    input logic [15:0] la, input logic v,
    input logic [15:0] o, input logic [15:0] p,
    input logic [15:0] p1, input logic r,
    input logic [15:0] ad);
    vec_t t;
    t.stall = s; t.ack = a; t.load = l;
    t.load_addr = la; t.valid = v; t.out = o;
    t.pc = p; t.plus1 = p1; t.rd_en = r;
    t.addr = ad;
    return t;
  endfunction

  initial begin
    n_tests = 0;
    n_fail = 0;
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    mem[16'h0000] = 16'h5A12;
    mem[16'h0001] = 16'h1234;
    mem[16'h0002] = 16'hABCD;
    mem[16'h0003] = 16'hDEAD;
    mem[16'h0040] = 16'hC0DE;
    mem[16'h0041] = 16'hBEEF;
    mem[16'hFFFF] = 16'hF00F;
    mem_rd_data = 16'h0000;

    // stall ack load laddr | valid out pc plus1 rd addr
    vecs[0]  = mk(0,0,0,0, 0,16'h0000,0,1, 1,0);
    vecs[1]  = mk(0,0,0,0, 0,16'h0000,0,1, 0,0);
    vecs[2]  = mk(0,0,0,0, 1,16'h5A12,0,1, 0,1);
    vecs[3]  = mk(0,1,0,0, 0,16'h5A12,0,1, 1,1);
    vecs[4]  = mk(0,1,0,0, 0,16'h5A12,0,1, 0,1);
    vecs[5]  = mk(0,1,0,0, 1,16'h1234,1,2, 0,2);
    vecs[6]  = mk(1,1,0,0, 1,16'h1234,1,2, 0,2);
    vecs[7]  = mk(1,1,0,0, 1,16'h1234,1,2, 0,2);
    vecs[8]  = mk(1,1,0,0, 1,16'h1234,1,2, 0,2);
    vecs[9]  = mk(1,1,0,0, 1,16'h1234,1,2, 0,2);
    vecs[10] = mk(0,1,0,0, 0,16'h1234,1,2, 1,2);
    vecs[11] = mk(1,0,0,0, 0,16'h1234,1,2, 0,2);
    vecs[12] = mk(0,0,0,0, 1,16'hABCD,2,3, 0,3);
    vecs[13] = mk(0,0,0,0, 1,16'hABCD,2,3, 0,3);

    reset = 1'b0;
    stall = 1'b0;
    instr_ack = 1'b0;
    pc_load = 1'b0;
    pc_load_addr = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 0, 16'h0000, 0, 1, 0, 0);
    reset = 1'b1;

    for (int i = 0; i < 14; i++) begin
      tick(vecs[i].stall, vecs[i].ack,
           vecs[i].load, vecs[i].load_addr);
      chk_all($sformatf("v%0d", i), vecs[i].valid,
              vecs[i].out, vecs[i].pc, vecs[i].plus1,
              vecs[i].rd_en, vecs[i].addr);
    end

    // redirect while the read of 0x0003 is in WAIT
    tick(0, 1, 0, 0);
    chk_all("ld_req", 0, 16'hABCD, 2, 3, 1, 3);
    tick(0, 0, 0, 0);
    tick(0, 0, 1, 16'h0040);
    chk_all("ld_sq", 0, 16'hABCD, 2, 3, 1, 16'h0040);
    tick(0, 0, 0, 0);
    chk_all("ld_wait", 0, 16'hABCD, 2, 3, 0, 16'h0040);
    tick(0, 0, 0, 0);
    chk_all("ld_val", 1, 16'hC0DE, 16'h0040,
            16'h0041, 0, 16'h0041);

    // wrap at the top of the address space
    tick(0, 0, 1, 16'hFFFF);
    chk_all("wr_req", 0, 16'hC0DE, 16'h0040,
            16'h0041, 1, 16'hFFFF);
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    chk_all("wr_top", 1, 16'hF00F, 16'hFFFF,
            16'h0000, 0, 16'h0000);
    tick(0, 1, 0, 0);
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    chk_all("wr_zero", 1, 16'h5A12, 0, 1, 0, 1);

    // reset asserted while a read is in WAIT
    tick(0, 1, 0, 0);
    tick(0, 0, 0, 0);
    reset = 1'b0;
    tick(0, 0, 0, 0);
    chk_all("rs_wait", 0, 16'h0000, 0, 1, 0, 0);
    reset = 1'b1;
    tick(0, 0, 0, 0);
    chk_all("rs_req", 0, 16'h0000, 0, 1, 1, 0);
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    chk_all("rs_val", 1, 16'h5A12, 0, 1, 0, 1);

    // redirect taken straight out of IDLE
    reset = 1'b0;
    tick(0, 0, 0, 0);
    reset = 1'b1;
    tick(0, 0, 1, 16'h0041);
    chk_all("id_req", 0, 16'h0000, 0, 1, 1, 16'h0041);
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    chk_all("id_val", 1, 16'hBEEF, 16'h0041,
            16'h0042, 0, 16'h0042);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
